execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
Parametrised, registered execute stage that supersedes the combinational execute stage.
- Computes ALU result, Zero, signed overflow, branch target and destination register, then registers them into the EX/MEM boundary.
- Adds an iterative signed/unsigned multiplier with HI/LO registers, and MFHI/MFLO reads.
- Drives a Stall handshake to the upstream ID/EX register while a multiply is in progress.

Parameters:
DATA_W, 32, datapath width in bits (≥8, power of two)
REG_ADDR_W, 5, register-file address width
SH_W, $clog2(DATA_W), shift-amount width (derived; do not override)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Flush  input  1  drop the current accepted instruction (EX/MEM bubble)
In_Valid  input  1  ID/EX register holds a valid instruction
ALUOp  input  4  decoded operation (encoding below)
ALUSrc0  input  1  A-operand select: 0=Reg_Data1, 1=zero-extended Shamt
ALUSrc1  input  2  B-operand select: 0=Reg_Data2, 1=Imm, 2=constant 8, 3=constant 10
RegDst  input  1  destination select: 0=rt, 1=rd
RegWrite  input  1  instruction writes a GPR
Shamt  input  SH_W  shift amount
Reg_Data1, Reg_Data2  input  DATA_W  register operands
Imm  input  DATA_W  sign-extended immediate
PCPlusFour  input  DATA_W  PC+4 of the instruction
rt, rd  input  REG_ADDR_W  register specifiers
Stall  output  1  upstream must hold ID/EX contents
Out_Valid  output  1  EX/MEM contents valid
Out_RegWrite  output  1  registered GPR write enable
ALUResult  output  DATA_W  registered result
Zero  output  1  registered (result == 0)
Overflow  output  1  registered signed overflow (ADD/SUB only)
PC_Plus_Branch  output  DATA_W  registered PCPlusFour + (Imm << 2)
RegDestSelected  output  REG_ADDR_W  registered destination register
HI, LO  output  DATA_W  multiply result registers

Behaviour:
Reset:
- All outputs are 0 at the next edge; FSM goes to IDLE; counter, HI and LO clear.
- Reset overrides everything, including a multiply in flight.

ALUOp encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU.
- 8 SLL, 9 SRL, 10 SRA: B is shifted by A[SH_W-1:0].
- 11 LUI: B << (DATA_W/2).
- 12 MULT, 13 MULTU, 14 MFHI, 15 MFLO.

FSM: IDLE, MUL_BUSY.
- Stall = (state == MUL_BUSY), combinational from state only.

Accept rule:
- An instruction is accepted at an edge when In_Valid=1, Stall=0 and Flush=0.
- Flush=1 or In_Valid=0 in IDLE gives a bubble next cycle: Out_Valid=0, Out_RegWrite=0; the other outputs are don't-care but hold their previous value.

Single-cycle ops (0–11, 14, 15): latency 1 edge.
- Out_Valid=1 and Out_RegWrite=RegWrite.
- All EX/MEM outputs are registered from the current inputs.
- MFHI/MFLO return the HI/LO value at the accept edge.

Overflow:
- Set for ADD when both operand signs are equal and the result sign differs.
- Set for SUB when the operand signs differ and the result sign differs from A.
- 0 for all other ops.
- Overflow does not suppress Out_RegWrite; trap handling is out of scope.

MULT/MULTU accept:
- Operands are captured.
- For MULT, magnitudes are taken and a negate flag is recorded (sign A XOR sign B).
- Counter is loaded with DATA_W; FSM goes to MUL_BUSY.
- Out_Valid=0 and Out_RegWrite=0 at that edge.

MUL_BUSY:
- One shift-add iteration per cycle.
- Counter decrements; HI/LO keep their old values until completion.
- Out_Valid stays 0 for every busy cycle.
- In_Valid and Flush are ignored; the multiply is committed and not flushable.

Completion:
- On the edge where the counter reaches 0, {HI,LO} is written with the 2·DATA_W-bit product, two's-complement negated if the negate flag is set.
- FSM returns to IDLE.
- Stall is high for exactly DATA_W cycles after the accept edge.
- The next instruction, held upstream, is accepted on the first IDLE edge.

Width/hazard rules:
- Branch adder and ALU arithmetic are modulo 2^DATA_W.
- SLT/SLTU results are zero-extended to DATA_W.
- MFHI/MFLO immediately after MULT are correct without interlock, because Stall holds them until HI/LO are written.

Test Plan:
1. Reset held 2 cycles mid-MULT (counter=17), then released → all outputs 0, Stall=0, HI=LO=0, next ADD accepted normally.
2. ADD 0x7FFFFFFF+1, ALUSrc1=0, RegDst=1, rd=9, RegWrite=1 → next edge: ALUResult=0x80000000, Overflow=1, Zero=0, RegDestSelected=9, Out_RegWrite=1. SUB 5−5 → Zero=1, Overflow=0.
3. MULT −3×7 → Stall high 32 cycles, Out_Valid low throughout, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFHI held during the stall is accepted next → ALUResult=0xFFFFFFFF.
4. MULTU 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE. Flush asserted during MUL_BUSY → no effect on the product.
5. SRA with ALUSrc0=1, Shamt=4, B=0x80000000 → 0xF8000000. Branch with PCPlusFour=0x100, Imm=−4 → PC_Plus_Branch=0xF0.
6. Flush=1 with a valid ADD → Out_Valid=0, Out_RegWrite=0 next edge. Re-run tests 2–4 with DATA_W=16: MULT stall is 16 cycles, −3×7 gives HI=0xFFFF, LO=0xFFEB.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Registered execute stage: ALU, branch target and destination select into EX/MEM,
// plus an iterative shift-add multiplier with HI/LO and a Stall handshake to ID/EX.
module execute_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SH_W       = $clog2(DATA_W)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  In_Valid,
  input  logic [3:0]            ALUOp,
  input  logic                  ALUSrc0,
  input  logic [1:0]            ALUSrc1,
  input  logic                  RegDst,
  input  logic                  RegWrite,
  input  logic [SH_W-1:0]       Shamt,
  input  logic [DATA_W-1:0]     Reg_Data1,
  input  logic [DATA_W-1:0]     Reg_Data2,
  input  logic [DATA_W-1:0]     Imm,
  input  logic [DATA_W-1:0]     PCPlusFour,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  Stall,
  output logic                  Out_Valid,
  output logic                  Out_RegWrite,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  Zero,
  output logic                  Overflow,
  output logic [DATA_W-1:0]     PC_Plus_Branch,
  output logic [REG_ADDR_W-1:0] RegDestSelected,
  output logic [DATA_W-1:0]     HI,
  output logic [DATA_W-1:0]     LO
);

  localparam int CNT_W = SH_W + 1;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO
  } op_t;

  state_t              state;
  op_t                 op;
  logic [DATA_W-1:0]   op_a, op_b, result;
  logic [SH_W-1:0]     sh;
  logic                ovf;
  logic                is_mul;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] mcand, acc, acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                neg;

  assign op    = op_t'(ALUOp);
  assign Stall = (state == MUL_BUSY);
  assign sh    = op_a[SH_W-1:0];

  always_comb begin
    op_a = ALUSrc0 ? {{(DATA_W-SH_W){1'b0}}, Shamt} : Reg_Data1;
    case (ALUSrc1)
      2'd0:    op_b = Reg_Data2;
      2'd1:    op_b = Imm;
      2'd2:    op_b = DATA_W'(8);
      default: op_b = DATA_W'(10);
    endcase
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = op_a + op_b;
        ovf    = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        result = op_a - op_b;
        ovf    = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (result[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_NOR:  result = ~(op_a | op_b);
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, op_a < op_b};
      OP_SLL:  result = op_b << sh;
      OP_SRL:  result = op_b >> sh;
      OP_SRA:  result = $signed(op_b) >>> sh;
      OP_LUI:  result = op_b << (DATA_W/2);
      OP_MFHI: result = HI;
      OP_MFLO: result = LO;
      default: result = '0;
    endcase
  end

  // MULT runs the unsigned shift-add on magnitudes and fixes the sign at completion.
  assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign mag_a    = (op == OP_MULT && op_a[DATA_W-1]) ? -op_a : op_a;
  assign mag_b    = (op == OP_MULT && op_b[DATA_W-1]) ? -op_b : op_b;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      cnt             <= '0;
      mcand           <= '0;
      acc             <= '0;
      mplier          <= '0;
      neg             <= 1'b0;
      HI              <= '0;
      LO              <= '0;
      Out_Valid       <= 1'b0;
      Out_RegWrite    <= 1'b0;
      ALUResult       <= '0;
      Zero            <= 1'b0;
      Overflow        <= 1'b0;
      PC_Plus_Branch  <= '0;
      RegDestSelected <= '0;
    end else begin
      Out_Valid    <= 1'b0;
      Out_RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (In_Valid && !Flush) begin
            if (is_mul) begin
              mcand  <= {{DATA_W{1'b0}}, mag_a};
              mplier <= mag_b;
              acc    <= '0;
              neg    <= (op == OP_MULT) && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
              cnt    <= CNT_W'(DATA_W);
              state  <= MUL_BUSY;
            end else begin
              Out_Valid       <= 1'b1;
              Out_RegWrite    <= RegWrite;
              ALUResult       <= result;
              Zero            <= (result == '0);
              Overflow        <= ovf;
              PC_Plus_Branch  <= PCPlusFour + (Imm << 2);
              RegDestSelected <= RegDst ? rd : rt;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            {HI, LO} <= neg ? -acc_next : acc_next;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Drives a 32-bit and a 16-bit execute_stage_mc with the same instruction stream and
// checks both against an arithmetic reference model every cycle.
module tb_execute_stage_mc;

  typedef longint unsigned u64;

  logic        Clk;
  logic        s_reset, s_flush, s_valid;
  logic [3:0]  s_op;
  logic        s_src0, s_regdst, s_rw;
  logic [1:0]  s_src1;
  logic [4:0]  s_shamt, s_rt, s_rd;
  logic [31:0] s_d1, s_d2, s_imm, s_pc;
  logic        chk_en;

  int issue_id;
  int taken_id[2];
  int vectors, miscompares;

  logic        in_v[2];
  logic        o_stall[2], o_val[2], o_rw[2], o_zero[2], o_ovf[2];
  logic [31:0] o_res[2], o_pcb[2], o_hi[2], o_lo[2];
  logic [4:0]  o_dst[2];
  logic [15:0] r1_res, r1_pcb, r1_hi, r1_lo;

  // reference model state, one slot per instance (0 = 32-bit, 1 = 16-bit)
  bit  m_val[2], m_rw[2], m_zero[2], m_ovf[2], m_pin[2];
  u64  m_res[2], m_pcb[2], m_hi[2], m_lo[2], m_prod[2];
  bit [4:0] m_dst[2];
  int  m_busy[2];

  assign in_v[0] = s_valid && (taken_id[0] != issue_id);
  assign in_v[1] = s_valid && (taken_id[1] != issue_id);

  execute_stage_mc #(.DATA_W(32), .REG_ADDR_W(5)) dut32 (
    .Clk(Clk), .Reset(s_reset), .Flush(s_flush), .In_Valid(in_v[0]),
    .ALUOp(s_op), .ALUSrc0(s_src0), .ALUSrc1(s_src1), .RegDst(s_regdst), .RegWrite(s_rw),
    .Shamt(s_shamt), .Reg_Data1(s_d1), .Reg_Data2(s_d2), .Imm(s_imm), .PCPlusFour(s_pc),
    .rt(s_rt), .rd(s_rd), .Stall(o_stall[0]), .Out_Valid(o_val[0]), .Out_RegWrite(o_rw[0]),
    .ALUResult(o_res[0]), .Zero(o_zero[0]), .Overflow(o_ovf[0]), .PC_Plus_Branch(o_pcb[0]),
    .RegDestSelected(o_dst[0]), .HI(o_hi[0]), .LO(o_lo[0])
  );

  execute_stage_mc #(.DATA_W(16), .REG_ADDR_W(5)) dut16 (
    .Clk(Clk), .Reset(s_reset), .Flush(s_flush), .In_Valid(in_v[1]),
    .ALUOp(s_op), .ALUSrc0(s_src0), .ALUSrc1(s_src1), .RegDst(s_regdst), .RegWrite(s_rw),
    .Shamt(s_shamt[3:0]), .Reg_Data1(s_d1[15:0]), .Reg_Data2(s_d2[15:0]), .Imm(s_imm[15:0]),
    .PCPlusFour(s_pc[15:0]), .rt(s_rt), .rd(s_rd), .Stall(o_stall[1]), .Out_Valid(o_val[1]),
    .Out_RegWrite(o_rw[1]), .ALUResult(r1_res), .Zero(o_zero[1]), .Overflow(o_ovf[1]),
    .PC_Plus_Branch(r1_pcb), .RegDestSelected(o_dst[1]), .HI(r1_hi), .LO(r1_lo)
  );

  assign o_res[1] = {16'h0, r1_res};
  assign o_pcb[1] = {16'h0, r1_pcb};
  assign o_hi[1]  = {16'h0, r1_hi};
  assign o_lo[1]  = {16'h0, r1_lo};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic int wid(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic u64 msk(int w);
    return (u64'(1) << w) - 1;
  endfunction

  function automatic longint sx(u64 v, int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic u64 opa(int w);
    return s_src0 ? (u64'(s_shamt) & u64'(w - 1)) : (u64'(s_d1) & msk(w));
  endfunction

  function automatic u64 opb(int w);
    case (s_src1)
      2'd0:    return u64'(s_d2) & msk(w);
      2'd1:    return u64'(s_imm) & msk(w);
      2'd2:    return 8;
      default: return 10;
    endcase
  endfunction

  function automatic u64 alu_r(int w, u64 a, u64 b, u64 hi, u64 lo);
    u64 m;
    int sh;
    m  = msk(w);
    sh = int'(a & u64'(w - 1));
    case (s_op)
      4'd0:  return (a + b) & m;
      4'd1:  return (a - b) & m;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b) & m;
      4'd6:  return (sx(a, w) < sx(b, w)) ? 1 : 0;
      4'd7:  return (a < b) ? 1 : 0;
      4'd8:  return (b << sh) & m;
      4'd9:  return b >> sh;
      4'd10: return u64'(sx(b, w) >>> sh) & m;
      4'd11: return (b << (w / 2)) & m;
      4'd14: return hi;
      4'd15: return lo;
      default: return 0;
    endcase
  endfunction

  // overflow = the true signed sum/difference does not fit in w bits
  function automatic bit alu_v(int w, u64 a, u64 b);
    longint s, lim;
    lim = longint'(1) << (w - 1);
    if (s_op == 4'd0)      s = sx(a, w) + sx(b, w);
    else if (s_op == 4'd1) s = sx(a, w) - sx(b, w);
    else return 1'b0;
    return (s >= lim) || (s < -lim);
  endfunction

  function automatic u64 prod(int w, u64 a, u64 b);
    if (s_op == 4'd12) return u64'(sx(a, w) * sx(b, w));
    return a * b;
  endfunction

  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (s_reset) begin
        m_val[k] <= 0; m_rw[k] <= 0; m_zero[k] <= 0; m_ovf[k] <= 0; m_pin[k] <= 1;
        m_res[k] <= 0; m_pcb[k] <= 0; m_hi[k] <= 0; m_lo[k] <= 0; m_dst[k] <= 0;
        m_busy[k] <= 0;
      end else if (m_busy[k] != 0) begin
        m_val[k]  <= 0;
        m_rw[k]   <= 0;
        m_busy[k] <= m_busy[k] - 1;
        if (m_busy[k] == 1) begin
          m_hi[k] <= (m_prod[k] >> wid(k)) & msk(wid(k));
          m_lo[k] <= m_prod[k] & msk(wid(k));
        end
      end else begin
        m_val[k] <= 0;
        m_rw[k]  <= 0;
        if (in_v[k]) taken_id[k] <= issue_id;
        if (in_v[k] && !s_flush) begin
          m_pin[k] <= 0;
          if (s_op == 4'd12 || s_op == 4'd13) begin
            m_busy[k] <= wid(k);
            m_prod[k] <= prod(wid(k), opa(wid(k)), opb(wid(k)));
          end else begin
            m_val[k]  <= 1;
            m_rw[k]   <= s_rw;
            m_res[k]  <= alu_r(wid(k), opa(wid(k)), opb(wid(k)), m_hi[k], m_lo[k]);
            m_zero[k] <= alu_r(wid(k), opa(wid(k)), opb(wid(k)), m_hi[k], m_lo[k]) == 0;
            m_ovf[k]  <= alu_v(wid(k), opa(wid(k)), opb(wid(k)));
            m_pcb[k]  <= (u64'(s_pc) + (u64'(s_imm) << 2)) & msk(wid(k));
            m_dst[k]  <= s_regdst ? s_rd : s_rt;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stall%0d", k), o_stall[k], m_busy[k] != 0);
        chk($sformatf("valid%0d", k), o_val[k], m_val[k]);
        chk($sformatf("regwrite%0d", k), o_rw[k], m_rw[k]);
        chk($sformatf("hi%0d", k), o_hi[k], m_hi[k]);
        chk($sformatf("lo%0d", k), o_lo[k], m_lo[k]);
        if (m_val[k] || m_pin[k]) begin
          chk($sformatf("result%0d", k), o_res[k], m_res[k]);
          chk($sformatf("zero%0d", k), o_zero[k], m_zero[k]);
          chk($sformatf("ovf%0d", k), o_ovf[k], m_ovf[k]);
          chk($sformatf("pcb%0d", k), o_pcb[k], m_pcb[k]);
          chk($sformatf("dst%0d", k), o_dst[k], m_dst[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ins(input logic [3:0] op, input logic src0, input logic [1:0] src1,
                         input logic [31:0] d1, input logic [31:0] d2);
    s_op = op; s_src0 = src0; s_src1 = src1; s_d1 = d1; s_d2 = d2;
    s_imm = 0; s_pc = 0; s_shamt = 0; s_regdst = 0; s_rw = 1; s_rt = 5'd1; s_rd = 5'd2;
  endtask

  // present the instruction until both instances have taken (accepted or flushed) it
  task automatic go(input logic fl);
    int n;
    issue_id++;
    s_valid = 1;
    s_flush = fl;
    n = 0;
    do begin
      tick();
      s_flush = 0;
      n++;
    end while (!(taken_id[0] == issue_id && taken_id[1] == issue_id) && n < 300);
    s_valid = 0;
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: instruction %0d not accepted within 300 cycles", issue_id);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_stall[0] || o_stall[1]) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_timeout: Stall still high after 100 cycles");
    end
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return {$urandom_range(1) ? 16'h8000 : 16'h7FFF, $urandom_range(1) ? 16'h8000 : 16'h7FFF};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c0, c1;
    bit ov_seen;
    vectors = 0; miscompares = 0; issue_id = 0; chk_en = 0;
    s_valid = 0; s_flush = 0; s_reset = 1;
    set_ins(4'd0, 0, 2'd0, 0, 0);
    tick(); tick();
    chk_en = 1;
    chk("reset_valid", o_val[0], 0);
    chk("reset_stall", o_stall[0], 0);
    chk("reset_hi", o_hi[0], 0);
    s_reset = 0;

    // reset in the middle of a multiply (32-bit counter at 17)
    set_ins(4'd12, 0, 2'd0, 32'hFFFF_FFFD, 32'd7); go(0);
    repeat (15) tick();
    chk("busy_before_reset", o_stall[0], 1);
    s_reset = 1; tick(); tick();
    chk("midmul_stall0", o_stall[0], 0);
    chk("midmul_stall1", o_stall[1], 0);
    chk("midmul_hi0", o_hi[0], 0);
    chk("midmul_lo0", o_lo[0], 0);
    chk("midmul_res0", o_res[0], 0);
    chk("midmul_pcb0", o_pcb[0], 0);
    s_reset = 0;
    set_ins(4'd0, 0, 2'd0, 32'd2, 32'd3); go(0);
    chk("post_reset_add", o_res[0], 32'd5);
    chk("post_reset_valid", o_val[0], 1);

    // ADD overflow, SUB to zero
    set_ins(4'd0, 0, 2'd0, 32'h7FFF_FFFF, 32'd1); s_regdst = 1; s_rd = 5'd9; go(0);
    chk("add_res", o_res[0], 32'h8000_0000);
    chk("add_ovf", o_ovf[0], 1);
    chk("add_zero", o_zero[0], 0);
    chk("add_dst", o_dst[0], 5'd9);
    chk("add_rw", o_rw[0], 1);
    chk("model_add_ovf", m_ovf[0], 1);
    set_ins(4'd1, 0, 2'd0, 32'd5, 32'd5); go(0);
    chk("sub_zero", o_zero[0], 1);
    chk("sub_ovf", o_ovf[0], 0);

    // SRA by Shamt, branch target with negative immediate
    set_ins(4'd10, 1, 2'd0, 32'd0, 32'h8000_0000);
    s_shamt = 5'd4; s_imm = 32'hFFFF_FFFC; s_pc = 32'h100; go(0);
    chk("sra_res", o_res[0], 32'hF800_0000);
    chk("branch32", o_pcb[0], 32'hF0);
    chk("branch16", o_pcb[1], 32'hF0);

    // MULT -3 x 7: stall length and product at both widths
    set_ins(4'd12, 0, 2'd0, 32'hFFFF_FFFD, 32'd7); go(0);
    c0 = 0; c1 = 0; ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_stall[0]) c0++;
      if (o_stall[1]) c1++;
      if (o_val[0] || o_val[1]) ov_seen = 1;
      tick();
    end
    chk("stall_len32", c0, 32);
    chk("stall_len16", c1, 16);
    chk("valid_during_mul", ov_seen, 0);
    chk("mult_hi32", o_hi[0], 32'hFFFF_FFFF);
    chk("mult_lo32", o_lo[0], 32'hFFFF_FFEB);
    chk("mult_hi16", o_hi[1], 32'hFFFF);
    chk("mult_lo16", o_lo[1], 32'hFFEB);
    chk("model_lo32", m_lo[0], 32'hFFFF_FFEB);
    set_ins(4'd14, 0, 2'd0, 0, 0); go(0);
    chk("mfhi32", o_res[0], 32'hFFFF_FFFF);
    chk("mfhi16", o_res[1], 32'hFFFF);

    // MFLO held upstream behind a multiply
    set_ins(4'd12, 0, 2'd0, 32'hFFFF_FFFD, 32'd7); go(0);
    set_ins(4'd15, 0, 2'd0, 0, 0); go(0);
    chk("mflo_held32", o_res[0], 32'hFFFF_FFEB);
    chk("mflo_held16", o_res[1], 32'hFFEB);

    // MULTU with Flush pulsed while busy
    set_ins(4'd13, 0, 2'd0, 32'hFFFF_FFFF, 32'd2); go(0);
    s_flush = 1; repeat (6) tick(); s_flush = 0;
    wait_idle();
    chk("multu_hi32", o_hi[0], 32'h1);
    chk("multu_lo32", o_lo[0], 32'hFFFF_FFFE);
    chk("multu_hi16", o_hi[1], 32'h1);
    chk("multu_lo16", o_lo[1], 32'hFFFE);

    // flushed ADD becomes a bubble
    set_ins(4'd0, 0, 2'd0, 32'd1, 32'd1); go(1);
    chk("flush_valid32", o_val[0], 0);
    chk("flush_rw32", o_rw[0], 0);
    chk("flush_valid16", o_val[1], 0);

    // randomized stream
    for (int i = 0; i < 250; i++) begin
      s_op     = 4'($urandom_range(15));
      s_src0   = (s_op == 4'd12 || s_op == 4'd13) ? 1'b0 : 1'($urandom_range(1));
      s_src1   = (s_op == 4'd12 || s_op == 4'd13) ? 2'd0 : 2'($urandom_range(3));
      s_regdst = 1'($urandom_range(1));
      s_rw     = 1'($urandom_range(1));
      s_shamt  = 5'($urandom_range(31));
      s_d1     = rnd();
      s_d2     = rnd();
      s_imm    = rnd();
      s_pc     = $urandom;
      s_rt     = 5'($urandom_range(31));
      s_rd     = 5'($urandom_range(31));
      go($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) repeat ($urandom_range(2)) tick();
    end
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
